// File: rtl/logic_unit_n.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_n
//  Purpose  : Multi-mode bitwise logic unit. Processes LANE bits per cycle
//             under a start/busy/done handshake with a registered result.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_n #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rA,
  input  logic [WIDTH-1:0] rB,
  output logic [WIDTH-1:0] rZ,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam int N  = WIDTH / LANE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  generate
    if ((LANE < 1) || (WIDTH % LANE != 0)) begin : g_lane_check
      $error("logic_unit_n: WIDTH must be a non-zero multiple of LANE");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [KW-1:0]    r_k;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;

  logic             w_latch;
  logic             w_step;
  logic             w_last;
  logic [LANE-1:0]  w_a_chunk;
  logic [LANE-1:0]  w_b_chunk;
  logic [LANE-1:0]  w_chunk;
  logic [WIDTH-1:0] w_acc_next;

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output / control decode; busy depends on state only
  always_comb begin
    w_latch = (r_state == S_IDLE) && start;
    w_step  = (r_state == S_RUN);
    w_last  = w_step && (r_k == C_K_LAST);
    busy    = (r_state == S_RUN);
  end

  always_comb begin
    w_a_chunk = r_a[int'(r_k) * LANE +: LANE];
    w_b_chunk = r_b[int'(r_k) * LANE +: LANE];
    case (r_op)
      OP_OR:   w_chunk = w_a_chunk | w_b_chunk;
      OP_AND:  w_chunk = w_a_chunk & w_b_chunk;
      OP_XOR:  w_chunk = w_a_chunk ^ w_b_chunk;
      OP_NOR:  w_chunk = ~(w_a_chunk | w_b_chunk);
      OP_NAND: w_chunk = ~(w_a_chunk & w_b_chunk);
      OP_XNOR: w_chunk = ~(w_a_chunk ^ w_b_chunk);
      OP_NOTA: w_chunk = ~w_a_chunk;
      OP_PASS: w_chunk = w_b_chunk;
      default: w_chunk = '0;
    endcase
  end

  // Accumulator with the current chunk merged in, so the last edge can
  // publish the complete result without an extra cycle.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(r_k) * LANE +: LANE] = w_chunk;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_k   <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      rZ    <= '0;
      zero  <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= w_last;
      if (w_latch) begin
        r_a  <= rA;
        r_b  <= rB;
        r_op <= op;
        r_k  <= '0;
      end else if (w_step) begin
        r_acc <= w_acc_next;
        r_k   <= w_last ? '0 : r_k + 1'b1;
        if (w_last) begin
          rZ   <= w_acc_next;
          zero <= (w_acc_next == '0);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_n
//  Purpose  : Scoreboard bench for logic_unit_n (LANE=8 and LANE=32 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_n;

  logic        clk = 1'b0;
  logic        clear;
  logic        start, start1;
  logic [2:0]  op, op1;
  logic [31:0] rA, rB, rA1, rB1;
  logic [31:0] rZ, rZ1;
  logic        busy, done, zero, busy1, done1, zero1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  logic_unit_n #(.WIDTH(32), .LANE(8)) u_dut (
    .clk(clk), .clear(clear), .start(start), .op(op), .rA(rA), .rB(rB),
    .rZ(rZ), .busy(busy), .done(done), .zero(zero)
  );

  logic_unit_n #(.WIDTH(32), .LANE(32)) u_dut1 (
    .clk(clk), .clear(clear), .start(start1), .op(op1), .rA(rA1), .rB(rB1),
    .rZ(rZ1), .busy(busy1), .done(done1), .zero(zero1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse into the LANE=8 unit and log the expected result.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    sb_q.push_back(exp);
    op = o; rA = a; rB = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Tick until done, recording busy cycles, rZ movement and overlap.
  task automatic wait_done(output int busy_cnt, output bit timed_out,
                           output bit rz_moved, output bit overlap);
    logic [31:0] held;
    int n;
    held = rZ; busy_cnt = 0; rz_moved = 0; overlap = 0; n = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (rZ !== held) rz_moved = 1;
      tick();
      n++;
    end
    if (busy && done) overlap = 1;
    timed_out = !done;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = i[0]; op = 3'($urandom); rA = $urandom; rB = $urandom;
      tick();
      checks++;
      if (rZ !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: rZ=%h zero=%b busy=%b done=%b want 0/1/0/0", rZ, zero, busy, done);
      end
    end
    start = 1'b0;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rA = $urandom; rB = $urandom;
      tick();
      checks++;
      if (rZ !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_release: rZ=%h zero=%b busy=%b done=%b want 0/1/0/0", rZ, zero, busy, done);
      end
    end
  endtask

  task automatic test_or();
    int bc; bit to, mv, ov;
    logic [31:0] exp;
    issue(3'b000, 32'hF0F00000, 32'h0F0F00FF, 32'hFFFF00FF);
    wait_done(bc, to, mv, ov);
    exp = sb_q.pop_front();
    checks++;
    if (to || bc != 4) begin
      failures++;
      $display("FAIL or_latency: busy_cycles=%0d timeout=%0b want 4/0", bc, to);
    end
    checks++;
    if (rZ !== exp || zero !== 1'b0) begin
      failures++;
      $display("FAIL or_result: rZ=%h zero=%b want %h/0", rZ, zero, exp);
    end
    checks++;
    if (mv || ov) begin
      failures++;
      $display("FAIL or_hold: rz_moved=%0b busy_done_overlap=%0b want 0/0", mv, ov);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL or_pulse: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_isolation();
    int bc, extra; bit to, mv, ov;
    logic [31:0] exp;
    issue(3'b001, 32'hFFFFFFFF, 32'h12345678, 32'h12345678);
    rA = 32'h0; op = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(bc, to, mv, ov);
    exp = sb_q.pop_front();
    checks++;
    if (to || rZ !== exp) begin
      failures++;
      $display("FAIL iso_result: rZ=%h timeout=%0b want %h", rZ, to, exp);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL iso_ignored_start: extra_activity=%0d want 0", extra);
    end
  endtask

  typedef struct { logic [2:0] o; logic [31:0] a, b, e; logic z; } mode_t;

  task automatic test_modes();
    mode_t tbl[5];
    int bc; bit to, mv, ov;
    logic [31:0] exp;
    tbl[0] = '{3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b1};
    tbl[1] = '{3'b110, 32'h0000FFFF, 32'h13572468, 32'hFFFF0000, 1'b0};
    tbl[2] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[3] = '{3'b101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    tbl[4] = '{3'b111, 32'h5555AAAA, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    foreach (tbl[i]) begin
      issue(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].e);
      wait_done(bc, to, mv, ov);
      exp = sb_q.pop_front();
      checks++;
      if (to || rZ !== exp || zero !== tbl[i].z || bc != 4) begin
        failures++;
        $display("FAIL mode_op%0d: rZ=%h zero=%b busy_cycles=%0d timeout=%0b want %h/%b/4",
                 tbl[i].o, rZ, zero, bc, to, exp, tbl[i].z);
      end
      tick();
    end
  endtask

  task automatic test_abort_back_to_back();
    int bc, dones; bit to, mv, ov;
    logic [31:0] exp;
    issue(3'b000, 32'h000000F0, 32'h0000000F, 32'h0);
    void'(sb_q.pop_back());
    tick();
    #2 clear = 1'b0;
    #1;
    checks++;
    if (rZ !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: rZ=%h zero=%b busy=%b done=%b want 0/1/0/0", rZ, zero, busy, done);
    end
    tick();
    clear = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: dones=%0d busy=%b want 0/0", dones, busy);
    end
    issue(3'b011, 32'h0, 32'h0, 32'hFFFFFFFF);
    wait_done(bc, to, mv, ov);
    exp = sb_q.pop_front();
    checks++;
    if (to || rZ !== exp) begin
      failures++;
      $display("FAIL b2b_nor: rZ=%h timeout=%0b want %h", rZ, to, exp);
    end
    issue(3'b000, 32'h1, 32'h2, 32'h00000003);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    wait_done(bc, to, mv, ov);
    exp = sb_q.pop_front();
    checks++;
    if (to || bc != 4 || rZ !== exp || zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_or: rZ=%h zero=%b busy_cycles=%0d timeout=%0b want %h/0/4", rZ, zero, bc, to, exp);
    end
  endtask

  task automatic test_lane32();
    logic [31:0] exp;
    sb_q.push_back(32'h00000003);
    op1 = 3'b000; rA1 = 32'h1; rB1 = 32'h2; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || rZ1 !== 32'h0) begin
      failures++;
      $display("FAIL lane32_busy: busy=%b done=%b rZ=%h want 1/0/0", busy1, done1, rZ1);
    end
    tick();
    exp = sb_q.pop_front();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || rZ1 !== exp || zero1 !== 1'b0) begin
      failures++;
      $display("FAIL lane32_done: done=%b busy=%b rZ=%h zero=%b want 1/0/%h/0", done1, busy1, rZ1, zero1, exp);
    end
    tick();
    checks++;
    if (done1 !== 1'b0) begin
      failures++;
      $display("FAIL lane32_pulse: done=%b want 0", done1);
    end
  endtask

  initial begin
    clear = 1'b0; start = 1'b0; op = '0; rA = '0; rB = '0;
    start1 = 1'b0; op1 = '0; rA1 = '0; rB1 = '0;
    test_reset();
    test_or();
    test_isolation();
    test_modes();
    test_abort_back_to_back();
    test_lane32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_n.md
# logic_unit_n

Parametrised, multi-mode bitwise logic unit for the datapath ALU. It generalises the fixed 32-bit OR to any width and eight logic operations. Operands are processed LANE bits per cycle under a start/busy/done handshake, and the result is registered. It sits beside the other ALU function units and drives the Z-register input path, with a registered zero flag for branch logic.

## Interface
- WIDTH, 32, operand/result width in bits.
- LANE, 8, bits processed per cycle. WIDTH % LANE must equal 0, otherwise elaboration fails. N = WIDTH/LANE chunks.
- clk  input  1  rising-edge clock; one clock domain.
- clear  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation select, latched at start.
- rA  input  WIDTH  operand A, latched at start.
- rB  input  WIDTH  operand B, latched at start.
- rZ  output  WIDTH  registered result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- zero  output  1  registered (rZ == 0).

## Operation
- Op encoding:
  - 000 OR, 001 AND, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR, 110 NOT rA (rB ignored), 111 pass rB.
- States: IDLE, RUN.
- IDLE with start=1 at an edge:
  - latch rA, rB and op into internal registers;
  - chunk index k=0;
  - go to RUN.
- RUN, each edge:
  - compute result chunk [k*LANE +: LANE] from the latched chunks into an internal accumulator;
  - k increments.
- RUN, edge with k=N-1:
  - load rZ with the full accumulator, including the final chunk;
  - update zero from that value;
  - set done;
  - return to IDLE.
- rZ changes only at completion, never chunk-by-chunk. It holds the previous result throughout RUN.
- Changes on rA/rB/op during RUN have no effect.
- start during RUN is ignored (not queued).
- start high in the cycle done is high is accepted, because the state is IDLE. This allows back-to-back operations.
- k wraps to 0 on return to IDLE.

## Timing
- Reset (clear=0), effective immediately and asynchronously:
  - rZ=0, zero=1, busy=0, done=0;
  - state IDLE, k=0, accumulator=0.
- Reset mid-operation aborts the operation with no done pulse. rZ returns to 0.
- Latency, with start sampled at edge E:
  - busy=1 after edges E .. E+N-1;
  - rZ, zero and done update at edge E+N;
  - done=1 for exactly one cycle after edge E+N, then 0.
  - Busy and done are never high simultaneously.
- Throughput is one operation per N+1 cycles.
- N=1 (LANE=WIDTH): busy for one cycle, done after edge E+1.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold clear=0 with random inputs and start toggling -> rZ=0x00000000, zero=1, busy=0, done=0. Release clear -> outputs stay unchanged until start.
- OR (WIDTH=32, LANE=8): rA=0xF0F00000, rB=0x0F0F00FF, op=000, one-cycle start.
  - busy high for 4 cycles, then done for 1 cycle;
  - rZ=0xFFFF00FF, zero=0;
  - rZ holds its old value while busy.
- Operand isolation: start AND with rA=0xFFFFFFFF, rB=0x12345678. During busy, drive rA=0 and pulse start.
  - rZ=0x12345678;
  - exactly one done;
  - the second start is not executed.
- Modes:
  - XOR 0xDEADBEEF with 0xDEADBEEF -> rZ=0, zero=1;
  - NOT rA=0x0000FFFF -> rZ=0xFFFF0000;
  - NAND 0xFFFFFFFF with 0xFFFFFFFF -> 0;
  - XNOR 0 with 0 -> 0xFFFFFFFF;
  - pass rB=0xA5A5A5A5 -> 0xA5A5A5A5.
- Abort and back-to-back:
  - pull clear low two cycles into an OR -> immediate reset values, no done pulse;
  - next, start NOR 0,0 -> 0xFFFFFFFF;
  - assert start again in the done cycle with OR 1,2 -> second done 5 cycles later, rZ=0x00000003.
- LANE=32 build: OR 0x1,0x2 -> busy 1 cycle, done at second edge, rZ=0x00000003.
